// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x16 register file, two combinational read ports, one write port
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module reg_file #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1_reg,
  input  logic [ADDR_W-1:0] read2_reg,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              w_en,
  output logic [WIDTH-1:0]  read1_data,
  output logic [WIDTH-1:0]  read2_data
);

  logic [WIDTH-1:0] entry [NREGS];

  // Each entry either loads write_data when selected or recirculates its value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_en && (write_reg == ADDR_W'(i))) begin
          entry[i] <= write_data;
        end
      end
    end
  end

`ifdef RF_BYPASS_EN
  // Forward the in-flight write only outside reset, so reset reads stay zero.
  logic bypass_live;
  assign bypass_live = rst && w_en;

  always_comb begin
    read1_data = entry[read1_reg];
    read2_data = entry[read2_reg];
    if (bypass_live && (read1_reg == write_reg)) begin
      read1_data = write_data;
    end
    if (bypass_live && (read2_reg == write_reg)) begin
      read2_data = write_data;
    end
  end
`else
  always_comb begin
    read1_data = entry[read1_reg];
    read2_data = entry[read2_reg];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file against an array model
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [2:0]  read1_reg;
  logic [2:0]  read2_reg;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        w_en;
  logic [15:0] read1_data;
  logic [15:0] read2_data;

  int tests;
  int fails;

  logic [15:0] model [8];

  reg_file #(.WIDTH(16), .NREGS(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .read1_reg  (read1_reg),
    .read2_reg  (read2_reg),
    .write_reg  (write_reg),
    .write_data (write_data),
    .w_en       (w_en),
    .read1_data (read1_data),
    .read2_data (read2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_read(input logic [2:0] addr);
    if (!rst) return 16'h0000;
`ifdef RF_BYPASS_EN
    if (w_en && addr == write_reg) return write_data;
`endif
    return model[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  // One rising edge; inputs are held stable across it, then the model applies the write.
  task automatic tick();
    logic       do_wr;
    logic [2:0] a;
    logic [15:0] d;
    do_wr = rst && w_en;
    a = write_reg;
    d = write_data;
    @(posedge clk);
    if (do_wr) model[a] = d;
    #1;
  endtask

  task automatic test_reset();
    w_en = 1'b0; write_reg = 3'd0; write_data = 16'h0; read1_reg = 3'd3; read2_reg = 3'd6;
    rst = 1'b0;
    clear_model();
    #1;
    tests++;
    if (read1_data !== 16'h0000 || read2_data !== 16'h0000) begin
      fails++;
      $display("FAIL reset_initial: got %h/%h expected 0000/0000", read1_data, read2_data);
    end
    tick();
    rst = 1'b1;
    w_en = 1'b1; write_reg = 3'd3; write_data = 16'hBEEF;
    tick();
    w_en = 1'b0;
    #1;
    tests++;
    if (read1_data !== 16'hBEEF) begin
      fails++;
      $display("FAIL reset_preload: got %h expected beef", read1_data);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1;
    tests++;
    if (read1_data !== 16'h0000) begin
      fails++;
      $display("FAIL reset_async_clear: got %h expected 0000", read1_data);
    end
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_write_readback();
    w_en = 1'b1; write_reg = 3'd5; write_data = 16'h1234;
    tick();
    w_en = 1'b0;
    read1_reg = 3'd5; read2_reg = 3'd5;
    #1;
    tests++;
    if (read1_data !== 16'h1234 || read2_data !== 16'h1234) begin
      fails++;
      $display("FAIL readback_r5: got %h/%h expected 1234/1234", read1_data, read2_data);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 5) continue;
      read1_reg = 3'(k); read2_reg = 3'(k);
      #1;
      tests++;
      if (read1_data !== 16'h0000 || read2_data !== 16'h0000) begin
        fails++;
        $display("FAIL readback_others r%0d: got %h/%h expected 0000/0000", k, read1_data, read2_data);
      end
    end
  endtask

  task automatic test_hold();
    w_en = 1'b0; write_reg = 3'd5; write_data = 16'hFFFF;
    read1_reg = 3'd5; read2_reg = 3'd5;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (read1_data !== 16'h1234 || read2_data !== 16'h1234) begin
      fails++;
      $display("FAIL hold_r5: got %h/%h expected 1234/1234", read1_data, read2_data);
    end
  endtask

  task automatic test_same_cycle();
    w_en = 1'b1; write_reg = 3'd2; write_data = 16'h00AA;
    tick();
    write_data = 16'h5555;
    read1_reg = 3'd2; read2_reg = 3'd5;
    #1;
    tests++;
`ifdef RF_BYPASS_EN
    if (read1_data !== 16'h5555) begin
      fails++;
      $display("FAIL same_cycle_pre: got %h expected 5555", read1_data);
    end
`else
    if (read1_data !== 16'h00AA) begin
      fails++;
      $display("FAIL same_cycle_pre: got %h expected 00aa", read1_data);
    end
`endif
    tests++;
    if (read2_data !== 16'h1234) begin
      fails++;
      $display("FAIL same_cycle_other_port: got %h expected 1234", read2_data);
    end
    tick();
    w_en = 1'b0;
    #1;
    tests++;
    if (read1_data !== 16'h5555) begin
      fails++;
      $display("FAIL same_cycle_post: got %h expected 5555", read1_data);
    end
  endtask

  task automatic test_walk();
    for (int k = 0; k < 8; k++) begin
      w_en = 1'b1; write_reg = 3'(k); write_data = 16'(16'h1111 * k);
      tick();
    end
    w_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      read1_reg = 3'(k); read2_reg = 3'(7 - k);
      #1;
      tests++;
      if (read1_data !== 16'(16'h1111 * k) || read2_data !== 16'(16'h1111 * (7 - k))) begin
        fails++;
        $display("FAIL walk pair(%0d,%0d): got %h/%h expected %h/%h", k, 7 - k,
                 read1_data, read2_data, 16'(16'h1111 * k), 16'(16'h1111 * (7 - k)));
      end
    end
  endtask

  task automatic test_write_blocked_by_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    w_en = 1'b1; write_reg = 3'd7; write_data = 16'hCAFE; read1_reg = 3'd7; read2_reg = 3'd7;
    #1;
    tests++;
    if (read1_data !== 16'h0000 || read2_data !== 16'h0000) begin
      fails++;
      $display("FAIL blocked_in_reset: got %h/%h expected 0000/0000", read1_data, read2_data);
    end
    tick();
    w_en = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (read1_data !== 16'h0000) begin
      fails++;
      $display("FAIL blocked_after_release: got %h expected 0000", read1_data);
    end
    w_en = 1'b1;
    tick();
    w_en = 1'b0;
    #1;
    tests++;
    if (read1_data !== 16'hCAFE) begin
      fails++;
      $display("FAIL blocked_then_write: got %h expected cafe", read1_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      w_en       = 1'($urandom_range(0, 1));
      write_reg  = 3'($urandom_range(0, 7));
      write_data = 16'($urandom);
      read1_reg  = 3'($urandom_range(0, 7));
      read2_reg  = ($urandom_range(0, 3) == 0) ? write_reg : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        clear_model();
      end else begin
        rst = 1'b1;
      end
      #1;
      e1 = exp_read(read1_reg);
      e2 = exp_read(read2_reg);
      tests++;
      if (read1_data !== e1 || read2_data !== e2) begin
        fails++;
        $display("FAIL random iter %0d rst=%0b w_en=%0b wr=%0d rd=%0d/%0d: got %h/%h expected %h/%h",
                 i, rst, w_en, write_reg, read1_reg, read2_reg, read1_data, read2_data, e1, e2);
      end
      tick();
    end
    rst = 1'b1;
    w_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      read1_reg = 3'(k); read2_reg = 3'(7 - k);
      #1;
      tests++;
      if (read1_data !== model[k] || read2_data !== model[7 - k]) begin
        fails++;
        $display("FAIL random_final r%0d: got %h/%h expected %h/%h", k,
                 read1_data, read2_data, model[k], model[7 - k]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_readback();
    test_hold();
    test_same_cycle();
    test_walk();
    test_write_blocked_by_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
